// File: rtl/prog_mem_loadable_pkg.sv
// Shared constants for the loadable BIP program memory: default geometry,
// BIP opcode encodings and the load FSM state type.
package prog_mem_loadable_pkg;

    // Default geometry; the top module exposes these as overridable parameters.
    localparam int unsigned DFLT_NBITS_O   = 11;
    localparam int unsigned DFLT_NBITS_D   = 16;
    localparam int unsigned DFLT_NBITS_B   = 8;
    localparam int unsigned DFLT_NBITS_OPC = 5;
    localparam int unsigned DFLT_CELDAS    = 1024;

    localparam logic [DFLT_NBITS_OPC-1:0] DFLT_HALT_OPC  = 5'b00000;
    localparam logic [DFLT_NBITS_D-1:0]   DFLT_DATA_WORD = 16'hF800;

    // BIP opcodes (word MSBs).
    localparam logic [DFLT_NBITS_OPC-1:0] OPC_HLT  = 5'b00000;
    localparam logic [DFLT_NBITS_OPC-1:0] OPC_STO  = 5'b00001;
    localparam logic [DFLT_NBITS_OPC-1:0] OPC_LD   = 5'b00010;
    localparam logic [DFLT_NBITS_OPC-1:0] OPC_LDI  = 5'b00011;
    localparam logic [DFLT_NBITS_OPC-1:0] OPC_ADD  = 5'b00100;
    localparam logic [DFLT_NBITS_OPC-1:0] OPC_ADDI = 5'b00101;
    localparam logic [DFLT_NBITS_OPC-1:0] OPC_SUB  = 5'b00110;
    localparam logic [DFLT_NBITS_OPC-1:0] OPC_SUBI = 5'b00111;

    // Load FSM states.
    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StRxHi  = 3'd1,
        StRxLo  = 3'd2,
        StWrite = 3'd3,
        StDone  = 3'd4,
        StErr   = 3'd5
    } state_e;

endpackage

// File: rtl/prog_mem_loadable_if.sv
// Loader and fetch signals of the loadable program memory.
// master = loader/CPU side, slave = memory side.
interface prog_mem_loadable_if import prog_mem_loadable_pkg::*; #(
    parameter int unsigned NBITS_O = DFLT_NBITS_O,
    parameter int unsigned NBITS_D = DFLT_NBITS_D,
    parameter int unsigned NBITS_B = DFLT_NBITS_B
);
    // Loader side
    logic               i_load_start;
    logic               i_byte_valid;
    logic [NBITS_B-1:0] i_byte;
    logic               o_byte_ready;
    logic               o_load_done;
    logic               o_load_err;
    logic [NBITS_O:0]   o_word_count;
    logic               o_busy;
    // Fetch side
    logic               i_rd_en;
    logic [NBITS_O-1:0] i_Addr;
    logic [NBITS_D-1:0] o_Data;
    logic               o_data_valid;

    modport master (
        output i_load_start, i_byte_valid, i_byte, i_rd_en, i_Addr,
        input  o_byte_ready, o_load_done, o_load_err, o_word_count, o_busy, o_Data, o_data_valid
    );

    modport slave (
        input  i_load_start, i_byte_valid, i_byte, i_rd_en, i_Addr,
        output o_byte_ready, o_load_done, o_load_err, o_word_count, o_busy, o_Data, o_data_valid
    );

endinterface

// File: rtl/prog_mem_loadable_ram.sv
// CELDAS x NBITS_D storage: one synchronous write port, one registered read port.
// The array is never reset so loaded programs survive a reset.
module prog_mem_loadable_ram #(
    parameter int unsigned CELDAS  = 1024,
    parameter int unsigned NBITS_D = 16,
    parameter int unsigned AW      = 10
) (
    input  logic               i_clk,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [NBITS_D-1:0] wr_data,
    input  logic               rd_en,
    input  logic [AW-1:0]      rd_addr,
    output logic [NBITS_D-1:0] rd_data
);

    logic [NBITS_D-1:0] mem [CELDAS];

    // Write and registered read; callers keep addresses below CELDAS.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/prog_mem_loadable.sv
// Runtime-loadable BIP instruction memory. A byte stream (high byte first) is
// packed into words written at auto-incremented addresses; a HALT word ends the
// load, filling the memory without one flags an error. When not loading, fetches
// return the addressed word one cycle later with a valid pulse.
module prog_mem_loadable import prog_mem_loadable_pkg::*; #(
    parameter int unsigned         NBITS_O   = DFLT_NBITS_O,
    parameter int unsigned         NBITS_D   = DFLT_NBITS_D,  // must equal 2*NBITS_B
    parameter int unsigned         NBITS_B   = DFLT_NBITS_B,
    parameter int unsigned         NBITS_OPC = DFLT_NBITS_OPC,
    parameter int unsigned         CELDAS    = DFLT_CELDAS,   // <= 2**NBITS_O
    parameter logic [NBITS_OPC-1:0] HALT_OPC = DFLT_HALT_OPC,
    parameter logic [NBITS_D-1:0]   DEF_WORD = DFLT_DATA_WORD
) (
    input logic                i_clk,
    input logic                i_reset,
    prog_mem_loadable_if.slave bus
);

    localparam int unsigned        AW        = (CELDAS > 1) ? $clog2(CELDAS) : 1;
    localparam logic [NBITS_O:0]   CELDAS_W  = (NBITS_O + 1)'(CELDAS);
    localparam logic [NBITS_O-1:0] LAST_ADDR = NBITS_O'(CELDAS - 1);

    state_e             state_q;
    logic [NBITS_B-1:0] hi_q;
    logic [NBITS_D-1:0] word_q;
    logic [NBITS_O-1:0] wptr_q;
    logic [NBITS_O:0]   count_q;
    logic               ready_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;

    logic               sel_def_q;
    logic               data_valid_q;
    logic [NBITS_D-1:0] ram_rdata;

    logic accept;
    logic halt_word;
    logic wr_en;
    logic rd_ok;
    logic in_range;

    // Start has priority over a byte offered in the same cycle.
    assign accept    = bus.i_byte_valid & ready_q & ~bus.i_load_start;
    assign halt_word = (word_q[NBITS_D-1 -: NBITS_OPC] == HALT_OPC);
    assign wr_en     = (state_q == StWrite);
    assign rd_ok     = bus.i_rd_en & ~busy_q;
    assign in_range  = ({1'b0, bus.i_Addr} < CELDAS_W);

    // Load FSM: byte packing, write pointer, word count and registered status outputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= StIdle;
            hi_q    <= '0;
            word_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (bus.i_load_start) begin
            state_q <= StRxHi;
            wptr_q  <= '0;
            count_q <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                StRxHi: begin
                    if (accept) begin
                        hi_q    <= bus.i_byte;
                        state_q <= StRxLo;
                    end
                end
                StRxLo: begin
                    if (accept) begin
                        word_q  <= {hi_q, bus.i_byte};
                        state_q <= StWrite;
                        ready_q <= 1'b0;
                    end
                end
                StWrite: begin
                    count_q <= count_q + (NBITS_O + 1)'(1);
                    if (halt_word) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (wptr_q == LAST_ADDR) begin
                        // Memory full without a HALT word; the pointer never wraps.
                        state_q <= StErr;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end else begin
                        wptr_q  <= wptr_q + NBITS_O'(1);
                        state_q <= StRxHi;
                        ready_q <= 1'b1;
                    end
                end
                default: ;  // IDLE, DONE, ERR wait for the next start
            endcase
        end
    end

    // Fetch tracking: valid pulse and whether o_Data shows DEF_WORD or the RAM output.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sel_def_q    <= 1'b1;
            data_valid_q <= 1'b0;
        end else begin
            data_valid_q <= rd_ok;
            if (rd_ok) begin
                sel_def_q <= ~in_range;
            end
        end
    end

    prog_mem_loadable_ram #(
        .CELDAS  (CELDAS),
        .NBITS_D (NBITS_D),
        .AW      (AW)
    ) u_ram (
        .i_clk   (i_clk),
        .wr_en   (wr_en),
        .wr_addr (wptr_q[AW-1:0]),
        .wr_data (word_q),
        .rd_en   (rd_ok & in_range),
        .rd_addr (bus.i_Addr[AW-1:0]),
        .rd_data (ram_rdata)
    );

    assign bus.o_byte_ready = ready_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_load_done  = done_q;
    assign bus.o_load_err   = err_q;
    assign bus.o_word_count = count_q;
    assign bus.o_data_valid = data_valid_q;
    // RAM read register holds across idle cycles, so o_Data holds with it.
    assign bus.o_Data       = sel_def_q ? DEF_WORD : ram_rdata;

endmodule

// File: tb/tb_prog_mem_loadable.sv
// Bench for prog_mem_loadable: a full-size instance (dut A) and a CELDAS=4
// instance (dut B) share stimulus, steered by sel. Fetch expectations go into a
// per-instance queue; a negedge monitor pops and compares on each valid pulse.
module tb_prog_mem_loadable;

    typedef struct {
        logic [15:0] data;
        bit          chk;
        int          due;
    } exp_t;

    logic clk;
    logic rst;
    int   sel;
    int   cyc;
    int   n_cmp;
    int   n_bad;

    logic        load_start;
    logic        byte_valid;
    logic [7:0]  ld_byte;
    logic        rd_en;
    logic [10:0] addr;

    logic        ready;
    logic        busy;
    logic        done;
    logic        err;
    logic [11:0] count;
    logic [15:0] data;
    logic        valid;

    exp_t q [2][$];

    prog_mem_loadable_if bus_a ();
    prog_mem_loadable_if bus_b ();

    assign bus_a.i_load_start = load_start & (sel == 0);
    assign bus_a.i_byte_valid = byte_valid & (sel == 0);
    assign bus_a.i_byte       = ld_byte;
    assign bus_a.i_rd_en      = rd_en & (sel == 0);
    assign bus_a.i_Addr       = addr;
    assign bus_b.i_load_start = load_start & (sel == 1);
    assign bus_b.i_byte_valid = byte_valid & (sel == 1);
    assign bus_b.i_byte       = ld_byte;
    assign bus_b.i_rd_en      = rd_en & (sel == 1);
    assign bus_b.i_Addr       = addr;

    assign ready = (sel == 1) ? bus_b.o_byte_ready : bus_a.o_byte_ready;
    assign busy  = (sel == 1) ? bus_b.o_busy       : bus_a.o_busy;
    assign done  = (sel == 1) ? bus_b.o_load_done  : bus_a.o_load_done;
    assign err   = (sel == 1) ? bus_b.o_load_err   : bus_a.o_load_err;
    assign count = (sel == 1) ? bus_b.o_word_count : bus_a.o_word_count;
    assign data  = (sel == 1) ? bus_b.o_Data       : bus_a.o_Data;
    assign valid = (sel == 1) ? bus_b.o_data_valid : bus_a.o_data_valid;

    prog_mem_loadable u_dut_a (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus_a)
    );

    prog_mem_loadable #(
        .CELDAS (4)
    ) u_dut_b (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every valid pulse must match the queue head, exactly one cycle after issue.
    always @(negedge clk) begin
        logic        dv;
        logic [15:0] dd;
        exp_t        e;
        for (int k = 0; k < 2; k++) begin
            dv = (k == 0) ? bus_a.o_data_valid : bus_b.o_data_valid;
            dd = (k == 0) ? bus_a.o_Data : bus_b.o_Data;
            if (q[k].size() > 0 && q[k][0].due < cyc) begin
                e = q[k].pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL fetch_missing[%0d]: no valid at cycle %0d, expected data %0h",
                         k, e.due, e.data);
            end
            if (dv) begin
                if (q[k].size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_valid[%0d]: got valid=1 data %0h, expected valid=0",
                             k, dd);
                end else begin
                    e = q[k].pop_front();
                    check($sformatf("fetch_latency[%0d]", k), cyc, e.due);
                    if (e.chk) check($sformatf("fetch_data[%0d]", k), {16'h0, dd}, {16'h0, e.data});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        byte_valid = 1'b1;
        ld_byte    = b;
        while (!ready && n < 20) begin
            tick();
            n++;
        end
        if (!ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL byte_ready_timeout: got ready=0 for 20 cycles, expected ready=1");
        end
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        if (busy) begin
            n_cmp++;
            n_bad++;
            $display("FAIL load_timeout: got busy=1 for 20 cycles, expected busy=0");
        end
    endtask

    // Issue one fetch; if expect_v, the monitor must see it one cycle later.
    task automatic fetch(input logic [10:0] a, input logic [15:0] d, input bit chk,
                         input bit expect_v);
        exp_t e;
        rd_en = 1'b1;
        addr  = a;
        if (expect_v) begin
            e.data = d;
            e.chk  = chk;
            e.due  = cyc + 1;
            q[sel].push_back(e);
        end
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        cyc        = 0;
        n_cmp      = 0;
        n_bad      = 0;
        sel        = 0;
        rst        = 1'b1;
        load_start = 1'b0;
        byte_valid = 1'b0;
        ld_byte    = 8'h00;
        rd_en      = 1'b0;
        addr       = '0;
        tick();
        tick();

        // Reset state
        check("rst_data",  {16'h0, data}, 32'hF800);
        check("rst_valid", valid, 0);
        check("rst_ready", ready, 0);
        check("rst_busy",  busy, 0);
        check("rst_done",  done, 0);
        check("rst_err",   err, 0);
        check("rst_count", {20'h0, count}, 0);
        rst = 1'b0;
        tick();

        // Test 1: default word before any fetch, out-of-range fetch returns it with a pulse
        check("t1_data_before", {16'h0, data}, 32'hF800);
        fetch(11'd2000, 16'hF800, 1'b1, 1'b1);
        tick();

        // Test 2: three-word load ending on HALT, then back-to-back fetches
        start_load();
        check("t2_ready_after_start", ready, 1);
        check("t2_busy_after_start",  busy, 1);
        send_byte(8'h10); send_byte(8'h01);
        send_byte(8'h28); send_byte(8'h02);
        send_byte(8'h00); send_byte(8'h00);
        wait_idle();
        check("t2_done",  done, 1);
        check("t2_err",   err, 0);
        check("t2_count", {20'h0, count}, 3);
        check("t2_ready", ready, 0);
        fetch(11'd0, 16'h1001, 1'b1, 1'b1);
        fetch(11'd1, 16'h2802, 1'b1, 1'b1);
        fetch(11'd2, 16'h0000, 1'b1, 1'b1);
        tick();

        // Test 5a: fetch refused while loading, o_Data holds
        start_load();
        check("t5_done_cleared", done, 0);
        check("t5_count_cleared", {20'h0, count}, 0);
        fetch(11'd0, 16'h0000, 1'b0, 1'b0);
        check("t5_valid_busy", valid, 0);
        check("t5_data_hold",  {16'h0, data}, 32'h0000);

        // Test 4: restart drops the byte presented with start
        send_byte(8'h55);
        load_start = 1'b1;
        byte_valid = 1'b1;
        ld_byte    = 8'h77;
        tick();
        load_start = 1'b0;
        byte_valid = 1'b0;
        send_byte(8'hAB); send_byte(8'hCD);
        send_byte(8'h00); send_byte(8'h00);
        wait_idle();
        check("t4_done",  done, 1);
        check("t4_count", {20'h0, count}, 2);
        fetch(11'd1, 16'h0000, 1'b1, 1'b1);
        fetch(11'd2, 16'h0000, 1'b1, 1'b1);

        // Test 5b: out-of-range boundaries, then a final in-range fetch
        fetch(11'd1024, 16'hF800, 1'b1, 1'b1);
        fetch(11'd2047, 16'hF800, 1'b1, 1'b1);
        fetch(11'd0,    16'hABCD, 1'b1, 1'b1);
        tick();

        // Test 3: CELDAS=4 overflow without HALT
        sel = 1;
        start_load();
        send_byte(8'h11); send_byte(8'h22);
        send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h55); send_byte(8'h66);
        send_byte(8'h77); send_byte(8'h88);
        wait_idle();
        check("t3_err",   err, 1);
        check("t3_done",  done, 0);
        check("t3_count", {20'h0, count}, 4);
        check("t3_ready", ready, 0);
        byte_valid = 1'b1;
        ld_byte    = 8'h99;
        tick(); tick(); tick();
        byte_valid = 1'b0;
        check("t3_count_after_extra", {20'h0, count}, 4);
        check("t3_err_hold", err, 1);
        fetch(11'd3, 16'h7788, 1'b1, 1'b1);
        fetch(11'd4, 16'hF800, 1'b1, 1'b1);
        fetch(11'd0, 16'h1122, 1'b1, 1'b1);

        // HALT word at the last address wins over overflow
        start_load();
        send_byte(8'h11); send_byte(8'h22);
        send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h55); send_byte(8'h66);
        send_byte(8'h00); send_byte(8'h01);
        wait_idle();
        check("t3h_done",  done, 1);
        check("t3h_err",   err, 0);
        check("t3h_count", {20'h0, count}, 4);
        fetch(11'd3, 16'h0001, 1'b1, 1'b1);
        tick();

        // Test 6: asynchronous reset in RX_LO, memory survives
        sel = 0;
        start_load();
        send_byte(8'h12); send_byte(8'h34);
        send_byte(8'h56);
        check("t6_busy_pre", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_ready", ready, 0);
        check("t6_busy",  busy, 0);
        check("t6_done",  done, 0);
        check("t6_err",   err, 0);
        check("t6_count", {20'h0, count}, 0);
        check("t6_data",  {16'h0, data}, 32'hF800);
        check("t6_valid", valid, 0);
        tick();
        rst = 1'b0;
        tick();
        fetch(11'd0, 16'h1234, 1'b1, 1'b1);
        fetch(11'd1, 16'h0000, 1'b1, 1'b1);
        tick();
        tick();

        check("queue_a_empty", q[0].size(), 0);
        check("queue_b_empty", q[1].size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
